// File: rtl/key_conditioner_if.sv
// Bundle of the pushbutton/switch inputs and the conditioned outputs of
// key_conditioner. The master side drives the raw inputs and observes the
// conditioned outputs; the slave side is the conditioner itself.
interface key_conditioner_if #(
    parameter int NKEYS = 4
);
    logic [NKEYS-1:0] key_n;
    logic [9:0]       sw;
    logic [NKEYS-1:0] key_level;
    logic [NKEYS-1:0] key_press;
    logic [NKEYS-1:0] key_release;
    logic [9:0]       sw_sync;

    modport master (
        output key_n,
        output sw,
        input  key_level,
        input  key_press,
        input  key_release,
        input  sw_sync
    );

    modport slave (
        input  key_n,
        input  sw,
        output key_level,
        output key_press,
        output key_release,
        output sw_sync
    );
endinterface

// File: rtl/key_conditioner.sv
// key_conditioner: synchronizes and debounces active-low pushbuttons into a
// clean level plus single-cycle press/release pulses, and double-flop
// synchronizes the slide switches.
// Optional feature: define KEY_AUTOREPEAT_EN to emit additional key_press
// pulses while a key stays held (first after REPEAT_DELAY cycles, then every
// REPEAT_PERIOD cycles). Without the macro, exactly one press pulse is
// produced per accepted press.
module key_conditioner #(
    parameter int NKEYS           = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic              clk,
    input  logic              reset,
    key_conditioner_if.slave  bus
);

    // Counter sized for the longest interval any key can time.
    localparam int MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_ALL = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
    localparam int CW      = $clog2(MAX_ALL + 1);

    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] DC_LAST  = CW'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_AUTOREPEAT_EN
    localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RP_LAST  = CW'(REPEAT_PERIOD - 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } key_state_t;

    // Counters stop at all-ones instead of wrapping back to zero.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    logic [NKEYS-1:0] key_sync1_r;
    logic [NKEYS-1:0] key_sync2_r;
    logic [NKEYS-1:0] pressed_s;
    logic [9:0]       sw_sync1_r;
    logic [9:0]       sw_sync2_r;

    key_state_t       state_r [NKEYS];
    key_state_t       state_s [NKEYS];
    logic [CW-1:0]    cnt_r   [NKEYS];
    logic [CW-1:0]    cnt_s   [NKEYS];

    logic [NKEYS-1:0] level_r;
    logic [NKEYS-1:0] level_s;
    logic [NKEYS-1:0] press_r;
    logic [NKEYS-1:0] press_s;
    logic [NKEYS-1:0] release_r;
    logic [NKEYS-1:0] release_s;

`ifdef KEY_AUTOREPEAT_EN
    logic [CW-1:0]    rcnt_r  [NKEYS];
    logic [CW-1:0]    rcnt_s  [NKEYS];
    logic [NKEYS-1:0] rph_r;
    logic [NKEYS-1:0] rph_s;
`endif

    assign pressed_s       = ~key_sync2_r;
    assign bus.key_level   = level_r;
    assign bus.key_press   = press_r;
    assign bus.key_release = release_r;
    assign bus.sw_sync     = sw_sync2_r;

    // Two-flop synchronizers; keys reset to released so reset exit is quiet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_sync1_r <= {NKEYS{1'b1}};
            key_sync2_r <= {NKEYS{1'b1}};
            sw_sync1_r  <= 10'd0;
            sw_sync2_r  <= 10'd0;
        end else begin
            key_sync1_r <= bus.key_n;
            key_sync2_r <= key_sync1_r;
            sw_sync1_r  <= bus.sw;
            sw_sync2_r  <= sw_sync1_r;
        end
    end

    // Per-key debounce state, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NKEYS; k++) begin
                state_r[k] <= ST_IDLE;
                cnt_r[k]   <= CNT_ZERO;
`ifdef KEY_AUTOREPEAT_EN
                rcnt_r[k]  <= CNT_ZERO;
`endif
            end
`ifdef KEY_AUTOREPEAT_EN
            rph_r     <= {NKEYS{1'b0}};
`endif
            level_r   <= {NKEYS{1'b0}};
            press_r   <= {NKEYS{1'b0}};
            release_r <= {NKEYS{1'b0}};
        end else begin
            for (int k = 0; k < NKEYS; k++) begin
                state_r[k] <= state_s[k];
                cnt_r[k]   <= cnt_s[k];
`ifdef KEY_AUTOREPEAT_EN
                rcnt_r[k]  <= rcnt_s[k];
`endif
            end
`ifdef KEY_AUTOREPEAT_EN
            rph_r     <= rph_s;
`endif
            level_r   <= level_s;
            press_r   <= press_s;
            release_r <= release_s;
        end
    end

    // Next-state and output decode for every key's debounce FSM.
    always_comb begin
        press_s   = {NKEYS{1'b0}};
        release_s = {NKEYS{1'b0}};
        level_s   = level_r;
`ifdef KEY_AUTOREPEAT_EN
        rph_s     = {NKEYS{1'b0}};
`endif
        for (int k = 0; k < NKEYS; k++) begin
            state_s[k] = state_r[k];
            cnt_s[k]   = cnt_r[k];
`ifdef KEY_AUTOREPEAT_EN
            // Repeat timing is cleared on every path except staying in HELD.
            rcnt_s[k]  = CNT_ZERO;
`endif
            case (state_r[k])
                ST_IDLE: begin
                    cnt_s[k] = CNT_ZERO;
                    if (pressed_s[k]) begin
                        state_s[k] = ST_PRESS_WAIT;
                    end else begin
                        state_s[k] = ST_IDLE;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!pressed_s[k]) begin
                        state_s[k] = ST_IDLE;
                        cnt_s[k]   = CNT_ZERO;
                    end else if (cnt_r[k] == DC_LAST) begin
                        state_s[k] = ST_HELD;
                        cnt_s[k]   = CNT_ZERO;
                        level_s[k] = 1'b1;
                        press_s[k] = 1'b1;
                    end else begin
                        cnt_s[k]   = sat_inc(cnt_r[k]);
                    end
                end
                ST_HELD: begin
                    if (!pressed_s[k]) begin
                        state_s[k] = ST_RELEASE_WAIT;
                        cnt_s[k]   = CNT_ZERO;
                    end else begin
                        state_s[k] = ST_HELD;
`ifdef KEY_AUTOREPEAT_EN
                        // Phase 0 waits for the initial delay, phase 1 is periodic.
                        if ((!rph_r[k] && (rcnt_r[k] == RD_LAST)) ||
                            (rph_r[k] && (rcnt_r[k] == RP_LAST))) begin
                            press_s[k] = 1'b1;
                            rcnt_s[k]  = CNT_ZERO;
                            rph_s[k]   = 1'b1;
                        end else begin
                            rcnt_s[k]  = sat_inc(rcnt_r[k]);
                            rph_s[k]   = rph_r[k];
                        end
`endif
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (pressed_s[k]) begin
                        state_s[k]   = ST_HELD;
                        cnt_s[k]     = CNT_ZERO;
                    end else if (cnt_r[k] == DC_LAST) begin
                        state_s[k]   = ST_IDLE;
                        cnt_s[k]     = CNT_ZERO;
                        level_s[k]   = 1'b0;
                        release_s[k] = 1'b1;
                    end else begin
                        cnt_s[k]     = sat_inc(cnt_r[k]);
                    end
                end
                default: begin
                    state_s[k] = ST_IDLE;
                    cnt_s[k]   = CNT_ZERO;
                    level_s[k] = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner. The driver applies inputs on the
// falling edge and pushes the response expected after the next rising edge;
// the monitor pops and compares one entry per rising edge.
module tb_key_conditioner;
    localparam int NK = 4;
    localparam int DC = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    key_conditioner_if #(.NKEYS(NK)) bus();

    key_conditioner #(
        .NKEYS(NK),
        .DEBOUNCE_CYCLES(DC),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct packed {
        logic [3:0] level;
        logic [3:0] press;
        logic [3:0] rel;
        logic [9:0] sw_sync;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   done     = 1'b0;

    // Reference model: raw input history plus, per key, the accepted level,
    // how many consecutive edges the synchronized input has disagreed with it,
    // and how many edges the key has been continuously held.
    logic [3:0] m_k1, m_k2;
    logic [9:0] m_s1, m_s2;
    bit         m_lvl [NK];
    int         m_run [NK];
    int         m_held[NK];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    endtask

    task automatic model_push();
        exp_t e;
        bit   p;
        e = '0;
        if (reset) begin
            m_k1 = 4'hF; m_k2 = 4'hF; m_s1 = 10'd0; m_s2 = 10'd0;
            for (int k = 0; k < NK; k++) begin
                m_lvl[k] = 1'b0; m_run[k] = 0; m_held[k] = 0;
            end
        end else begin
            for (int k = 0; k < NK; k++) begin
                p = ~m_k2[k];
                if (p != m_lvl[k]) begin
                    // A change is accepted after DC+1 consecutive disagreeing samples.
                    m_run[k]++;
                    if (m_run[k] == DC + 1) begin
                        m_lvl[k] = p;
                        m_run[k] = 0;
                        m_held[k] = 0;
                        if (p) e.press[k] = 1'b1;
                        else   e.rel[k]   = 1'b1;
                    end
                end else begin
                    if (m_lvl[k]) begin
                        if (m_run[k] > 0) begin
                            m_held[k] = 0;
                        end else begin
                            m_held[k]++;
`ifdef KEY_AUTOREPEAT_EN
                            if (m_held[k] == RD || (m_held[k] > RD && ((m_held[k] - RD) % RP) == 0))
                                e.press[k] = 1'b1;
`endif
                        end
                    end
                    m_run[k] = 0;
                end
                e.level[k] = m_lvl[k];
            end
            m_k2 = m_k1; m_k1 = bus.key_n;
            m_s2 = m_s1; m_s1 = bus.sw;
            e.sw_sync = m_s2;
        end
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic [3:0] kn, input logic [9:0] s, input logic rst);
        @(negedge clk);
        bus.key_n = kn;
        bus.sw    = s;
        reset     = rst;
        model_push();
    endtask

    task automatic hold(input int n, input logic [3:0] kn, input logic [9:0] s);
        for (int i = 0; i < n; i++) cycle(kn, s, 1'b0);
    endtask

    // Assert reset between clock edges and verify the outputs clear at once.
    task automatic async_reset(input logic [3:0] kn);
        @(negedge clk);
        bus.key_n = kn;
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_level",   32'(bus.key_level),   32'h0);
        chk("async_reset_press",   32'(bus.key_press),   32'h0);
        chk("async_reset_release", 32'(bus.key_release), 32'h0);
        chk("async_reset_sw_sync", 32'(bus.sw_sync),     32'h0);
        model_push();
    endtask

    // Monitor: one expected entry is due after every rising edge.
    initial begin
        exp_t e;
        @(negedge clk);
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                if (!done) chk("scoreboard_underflow", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("key_level",   32'(bus.key_level),   32'(e.level));
                chk("key_press",   32'(bus.key_press),   32'(e.press));
                chk("key_release", 32'(bus.key_release), 32'(e.rel));
                chk("sw_sync",     32'(bus.sw_sync),     32'(e.sw_sync));
            end
        end
    end

    initial begin
        logic [3:0] kn;
        logic [9:0] s;
        int         rem[NK];

        reset     = 1'b1;
        bus.key_n = 4'hF;
        bus.sw    = 10'd0;

        // Reset, then a quiet period with keys idle.
        for (int i = 0; i < 3; i++) cycle(4'hF, 10'd0, 1'b1);
        hold(20, 4'hF, 10'd0);
        async_reset(4'hF);
        cycle(4'hF, 10'd0, 1'b1);
        hold(5, 4'hF, 10'd0);

        // Clean press and release on key 3.
        hold(10, 4'b0111, 10'd0);
        hold(10, 4'hF, 10'd0);

        // Short press glitch on key 0, then a release bounce while held.
        hold(3, 4'b1110, 10'd0);
        hold(10, 4'hF, 10'd0);
        hold(10, 4'b1110, 10'd0);
        hold(2, 4'hF, 10'd0);
        hold(8, 4'b1110, 10'd0);
        hold(10, 4'hF, 10'd0);

        // Keys 1 and 2 pressed together.
        hold(10, 4'b1001, 10'd0);
        hold(10, 4'hF, 10'd0);

        // Reset while key 3 is held, key still down afterwards.
        hold(8, 4'b0111, 10'd0);
        async_reset(4'b0111);
        cycle(4'b0111, 10'd0, 1'b1);
        hold(10, 4'b0111, 10'd0);
        hold(10, 4'hF, 10'd0);

        // Long hold on key 3 (auto-repeat window when compiled in).
        hold(30, 4'b0111, 10'd0);
        hold(10, 4'hF, 10'd0);

        // Switch synchronizer.
        hold(3, 4'hF, 10'h2A5);
        hold(3, 4'hF, 10'h15A);

        // Randomized key activity, switch changes and occasional resets.
        kn = 4'hF;
        s  = 10'd0;
        for (int k = 0; k < NK; k++) rem[k] = $urandom_range(1, 12);
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < NK; k++) begin
                rem[k]--;
                if (rem[k] <= 0) begin
                    kn[k]  = ~kn[k];
                    rem[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 25);
                end
            end
            if ($urandom_range(0, 3) == 0) s = 10'($urandom);
            cycle(kn, s, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
        end
        hold(15, 4'hF, s);

        done = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
